// File: rtl/rank_responder.sv
// Rank table with in-order request/response path, a bypass for an idle FIFO and a request FIFO otherwise.
// Optional drop counter built only with RANK_RESPONDER_DROPCNT_EN defined.
module rank_responder #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*WIDTH-1:0]   nodeWeight,
  input  logic [5:0]           request,
  output logic [WIDTH+5:0]     response,
  input  logic                 updValid,
  input  logic [4:0]           updIdx,
  input  logic [WIDTH-1:0]     updVal,
  output logic                 full,
  output logic [7:0]           dropCount
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] table_q [N];
  logic [4:0]       fifo_q  [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH+5:0] rsp_q, rsp_d;

  logic             req_vld;
  logic [4:0]       req_idx;
  logic             wr_en;
  logic             fifo_empty, fifo_full;
  logic             pop, bypass, push, serve;
  logic [4:0]       serve_idx;
  logic [WIDTH-1:0] rd_val;

  assign req_vld = request[5];
  assign req_idx = request[4:0];
  // Out-of-range updates never claim the table port, so a read can still go out.
  assign wr_en   = updValid && (int'(updIdx) < N);

  always_comb begin
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == DEPTH_C);
    pop        = !wr_en && !fifo_empty;
    bypass     = !wr_en && fifo_empty && req_vld;
    push       = req_vld && !bypass && (!fifo_full || pop);
    serve      = pop || bypass;
    serve_idx  = pop ? fifo_q[rd_ptr_q] : req_idx;

    rd_val = '0;
    for (int i = 0; i < N; i++) begin
      if (serve_idx == 5'(i)) rd_val = table_q[i];
    end

    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;

    rsp_d = '0;
    if (serve) rsp_d = {1'b1, serve_idx, rd_val};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) table_q[i] <= nodeWeight[i*WIDTH +: WIDTH];
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      rsp_q    <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wr_en && (updIdx == 5'(i))) table_q[i] <= updVal;
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      rsp_q    <= rsp_d;
    end
  end

  // Queue storage holds only indices and needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    if (!reset && push) fifo_q[wr_ptr_q] <= req_idx;
  end

  assign response = rsp_q;
  assign full     = fifo_full;

`ifdef RANK_RESPONDER_DROPCNT_EN
  logic       drop;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop       = req_vld && !bypass && fifo_full && !pop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign dropCount = drop_cnt_q;
`else
  assign dropCount = 8'd0;
`endif

endmodule

// File: tb/tb_rank_responder.sv
// Table-driven bench for rank_responder: per-cycle vectors plus an in-order response scoreboard.
module tb_rank_responder;
  localparam int N     = 4;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

`ifdef RANK_RESPONDER_DROPCNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N*WIDTH-1:0]   nodeWeight;
  logic [5:0]           request;
  logic [WIDTH+5:0]     response;
  logic                 updValid;
  logic [4:0]           updIdx;
  logic [WIDTH-1:0]     updVal;
  logic                 full;
  logic [7:0]           dropCount;

  rank_responder #(.N(N), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .nodeWeight(nodeWeight), .request(request),
    .response(response), .updValid(updValid), .updIdx(updIdx), .updVal(updVal),
    .full(full), .dropCount(dropCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        uv;
    logic [4:0]  ui;
    logic [15:0] ud;
    logic        qv;
    logic [4:0]  qi;
    logic [15:0] qexp;   // value the request must be answered with
    logic        qdrop;  // request is never answered
    logic        ev;     // response valid expected after this cycle's edge
    logic        ef;     // full expected after this cycle's edge
    int          ed;     // dropCount expected when the counter is built
  } vec_t;

  typedef struct {
    logic [4:0]  idx;
    logic [15:0] val;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(int uv, int ui, int ud, int qv, int qi, int qexp,
                              int qdrop, int ev, int ef, int ed);
    vec_t v;
    v.uv = 1'(uv); v.ui = 5'(ui); v.ud = 16'(ud);
    v.qv = 1'(qv); v.qi = 5'(qi); v.qexp = 16'(qexp); v.qdrop = 1'(qdrop);
    v.ev = 1'(ev); v.ef = 1'(ef); v.ed = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    exp_t e;
    updValid = v.uv;
    updIdx   = v.ui;
    updVal   = v.ud;
    request  = {v.qv, v.qi};
    if (v.qv && !v.qdrop) begin
      e.idx = v.qi;
      e.val = v.qexp;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    check({tag, " rsp_vld"}, 32'(response[WIDTH+5]), 32'(v.ev));
    check({tag, " full"}, 32'(full), 32'(v.ef));
    check({tag, " dropCount"}, 32'(dropCount), DROP_EN ? v.ed : 0);
    if (response[WIDTH+5]) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s rsp: got response %0h, expected none outstanding", tag, response);
      end else begin
        e = sb.pop_front();
        check({tag, " rsp_idx"}, 32'(response[WIDTH+4:WIDTH]), 32'(e.idx));
        check({tag, " rsp_val"}, 32'(response[WIDTH-1:0]), 32'(e.val));
      end
    end
  endtask

  initial begin
    // Bypass, blocked reads, out-of-range index, read-after-write, ignored update.
    vecs.push_back(mk(0, 0, 0,       1, 2, 'hFFFF, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,      0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 'h1234,  1, 0, 'h5555, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 'h1234,  1, 1, 'h1234, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 'h1234,  1, 3, 'h8000, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,      0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,       1, 7, 0,      0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,      0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 'hABCD,  0, 0, 0,      0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,       1, 0, 'hABCD, 0, 1, 0, 0));
    vecs.push_back(mk(1, 9, 'h7777,  1, 2, 'hFFFF, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,      0, 0, 0, 0));
    // Six requests under six update cycles: four queued, two dropped.
    vecs.push_back(mk(1, 3, 'h4242,  1, 0, 'hABCD, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 'h4242,  1, 1, 'h1234, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 'h4242,  1, 2, 'hFFFF, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 'h4242,  1, 3, 'h4242, 0, 0, 1, 0));
    vecs.push_back(mk(1, 3, 'h4242,  1, 0, 0,      1, 0, 1, 1));
    vecs.push_back(mk(1, 3, 'h4242,  1, 1, 0,      1, 0, 1, 2));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,      0, 0, 0, 2));
    // Full FIFO, then simultaneous pop and push.
    vecs.push_back(mk(1, 3, 'h4242,  1, 0, 'hABCD, 0, 0, 0, 2));
    vecs.push_back(mk(1, 3, 'h4242,  1, 1, 'h1234, 0, 0, 0, 2));
    vecs.push_back(mk(1, 3, 'h4242,  1, 2, 'hFFFF, 0, 0, 0, 2));
    vecs.push_back(mk(1, 3, 'h4242,  1, 3, 'h4242, 0, 0, 1, 2));
    vecs.push_back(mk(0, 0, 0,       1, 2, 'hFFFF, 0, 1, 1, 2));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,      0, 0, 0, 2));

    nodeWeight = {16'h8000, 16'hFFFF, 16'h8000, 16'h5555};
    reset      = 1'b1;
    updValid   = 1'b1;
    updIdx     = 5'd0;
    updVal     = 16'hDEAD;
    request    = 6'h21;
    repeat (3) @(posedge clk);
    #1;
    check("reset response", 32'(response), 32'd0);
    check("reset full", 32'(full), 32'd0);
    check("reset dropCount", 32'(dropCount), 32'd0);

    reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("v%0d", i));

    // Queue three requests (table[0] overwritten meanwhile), then reset mid-operation.
    step(mk(1, 0, 'h9999, 1, 1, 0, 1, 0, 0, 2), "pre_rst0");
    step(mk(1, 0, 'h9999, 1, 2, 0, 1, 0, 0, 2), "pre_rst1");
    step(mk(1, 0, 'h9999, 1, 3, 0, 1, 0, 0, 2), "pre_rst2");
    reset    = 1'b1;
    updValid = 1'b0;
    request  = 6'h00;
    @(posedge clk);
    #1;
    check("mid reset response", 32'(response), 32'd0);
    check("mid reset full", 32'(full), 32'd0);
    check("mid reset dropCount", 32'(dropCount), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), $sformatf("post_rst_idle%0d", i));
    step(mk(0, 0, 0, 1, 0, 'h5555, 0, 1, 0, 0), "reload0");
    step(mk(0, 0, 0, 1, 3, 'h8000, 0, 1, 0, 0), "reload3");
    step(mk(0, 0, 0, 1, 1, 'h8000, 0, 1, 0, 0), "reload1");
    step(mk(0, 0, 0, 0, 0, 0,      0, 0, 0, 0), "tail");

    check("outstanding at end", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rank_responder.md
RANK_RESPONDER -- requirements
Module: rank_responder

Interface
REQ-001 Parameter N, default 4, number of rank-table entries (1..31).
REQ-002 Parameter WIDTH, default 16, rank value width.
REQ-003 Parameter DEPTH, default 4, request FIFO depth (power of two, at least 2).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 nodeWeight  input  N*WIDTH  initial rank values; entry i is in bits [(i+1)*WIDTH-1 : i*WIDTH].
REQ-007 request  input  6  bit 5 is valid; bits [4:0] are the requested node index.
REQ-008 response  output  WIDTH+6  bit WIDTH+5 is valid; bits [WIDTH+4:WIDTH] are the echoed index; bits [WIDTH-1:0] are the value.
REQ-009 updValid  input  1  rank-table write strobe.
REQ-010 updIdx  input  5  rank-table write index.
REQ-011 updVal  input  WIDTH  rank-table write data.
REQ-012 full  output  1  high when the request FIFO holds DEPTH entries.
REQ-013 dropCount  output  8  count of dropped requests (see Configuration).

Function
REQ-014 Rank table SHALL be N x WIDTH registers with one access per cycle: either an update write or a request read.
REQ-015 An update SHALL have priority: when updValid=1 and updIdx<N, the write SHALL occur and no read SHALL be served that cycle.
REQ-016 An update with updIdx>=N SHALL be ignored, and a read may still be served that cycle.
REQ-017 When the FIFO is empty and a read slot is free, an incoming valid request SHALL bypass the FIFO and be served that cycle, with the response valid the next cycle (latency 1).
REQ-018 Otherwise a valid request SHALL be pushed into the FIFO, and the FIFO head SHALL be served on each free read slot.
REQ-019 Responses SHALL be returned strictly in request-arrival order.
REQ-020 A response SHALL be valid for exactly one cycle per served request; response[WIDTH+5] SHALL be 0 in all other cycles.
REQ-021 The response value SHALL be the table contents after all earlier-cycle writes, i.e. a read in the cycle after a write to the same index returns the new value.
REQ-022 A request index >= N SHALL produce a valid response with value 0 and the index echoed.
REQ-023 A push and a pop in the same cycle with the FIFO full SHALL both succeed, and the count SHALL stay at DEPTH.
REQ-024 A push with the FIFO full and no pop that cycle SHALL drop the request, and the FIFO SHALL be unchanged.
REQ-025 full SHALL reflect the registered FIFO count.
REQ-026 The FIFO read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-027 While reset=1: table[i] SHALL load nodeWeight entry i, the FIFO SHALL be emptied, response SHALL be 0, full SHALL be 0, dropCount SHALL be 0, and request and update inputs SHALL be ignored.
REQ-028 Reset asserted mid-operation SHALL discard queued requests with no response emitted for them.
REQ-029 The first request SHALL be accepted in the first cycle with reset=0.

Configuration
REQ-030 With macro RANK_RESPONDER_DROPCNT_EN defined, dropCount SHALL increment by 1 per dropped request and saturate at 255.
REQ-031 Without RANK_RESPONDER_DROPCNT_EN, dropCount SHALL be constant 0 and no counter register SHALL be built.

Verification
REQ-032 Reset with nodeWeight={8000,FFFF,8000,5555} (entries 3..0), then request idx 2 -> response valid the next cycle with idx 2, value FFFF.
REQ-033 updValid for 3 cycles (idx 1, value 1234) while requests idx 0,1,3 arrive back-to-back -> no responses for 3 cycles, then responses 0:5555, 1:1234, 3:8000 on consecutive cycles in that order.
REQ-034 Request idx 7 with N=4 -> valid response with idx 7, value 0.
REQ-035 Hold updValid for 6 cycles while 6 requests arrive, with DEPTH=4 -> full=1 after the 4th push, 2 requests dropped, and dropCount=2 with the macro or 0 without; the 4 queued requests are answered in order after updates stop.
REQ-036 FIFO full plus simultaneous pop and push -> no drop, and the new request is answered last.
REQ-037 Assert reset with 3 requests queued -> no further responses, full=0, and the table reloaded from nodeWeight.
